// File: rtl/flit_depacketizer_if.sv
// Pop port of the local flit buffer and reassembled-message port of the ejection reader.
interface flit_depacketizer_if #(
   parameter int MAX_WORDS = 4
);
   logic                    FIFO_EMPTY;
   logic [18:0]             RD_DATA;
   logic                    RD_EN;
   logic                    MSG_VALID;
   logic                    MSG_READY;
   logic [16*MAX_WORDS-1:0] MSG_DATA;
   logic [2:0]              MSG_WORDS;
   logic [3:0]              MSG_SRC;
   logic                    ERR;
   logic [7:0]              PKT_CNT;
   logic [7:0]              ERR_CNT;

   modport slave (
      input  FIFO_EMPTY, RD_DATA, MSG_READY,
      output RD_EN, MSG_VALID, MSG_DATA, MSG_WORDS, MSG_SRC, ERR, PKT_CNT, ERR_CNT
   );

   modport master (
      output FIFO_EMPTY, RD_DATA, MSG_READY,
      input  RD_EN, MSG_VALID, MSG_DATA, MSG_WORDS, MSG_SRC, ERR, PKT_CNT, ERR_CNT
   );
endinterface

// File: rtl/flit_depacketizer.sv
// Ring-node ejection reader: pops flits from the local buffer and reassembles
// head/body/tail wormhole packets into one parallel message, flagging malformed traffic.
module flit_depacketizer #(
   parameter logic [3:0] NODE_ID   = 4'd0,
   parameter int         MAX_WORDS = 4
) (
   input logic                CLK,
   input logic                RST,
   flit_depacketizer_if.slave bus
);
   localparam int               IDX_W    = $clog2(MAX_WORDS + 1);
   localparam int               DATA_W   = 16 * MAX_WORDS;
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(MAX_WORDS);

   localparam logic [1:0] CTRL_HEAD = 2'b01;
   localparam logic [1:0] CTRL_BODY = 2'b10;
   localparam logic [1:0] CTRL_TAIL = 2'b11;

   typedef enum logic [1:0] {IDLE, COLLECT, DROP, HOLD} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [3:0]        src_q, src_d;
   logic [2:0]        words_q, words_d;
   logic              err_q, err_d;
   logic [7:0]        pkt_cnt_q, pkt_cnt_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              rd_en;
   logic [1:0]        ctrl;
   logic [15:0]       payload;
   logic              head_ok;
   logic              store;

   assign rd_en   = !bus.FIFO_EMPTY && (state_q != HOLD) && !RST;
   assign ctrl    = bus.RD_DATA[17:16];
   assign payload = bus.RD_DATA[15:0];
   assign head_ok = bus.RD_DATA[18] && (payload[15:12] == NODE_ID);

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      idx_d     = idx_q;
      src_d     = src_q;
      words_d   = words_q;
      err_d     = 1'b0;
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      store     = 1'b0;

      if (state_q == HOLD) begin
         if (bus.MSG_READY) begin
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + 8'd1;
         end
      end else if (rd_en) begin
         case (ctrl)
            CTRL_HEAD: begin
               // A head always terminates whatever packet was in progress.
               if (state_q == COLLECT) begin
                  err_d = 1'b1;
               end
               if (head_ok) begin
                  src_d   = payload[11:8];
                  data_d  = '0;
                  idx_d   = '0;
                  state_d = COLLECT;
               end else begin
                  err_d   = 1'b1;
                  state_d = DROP;
               end
            end
            CTRL_BODY: begin
               if (state_q == COLLECT) begin
                  if (idx_q == IDX_FULL) begin
                     err_d   = 1'b1;
                     state_d = DROP;
                  end else begin
                     store = 1'b1;
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else if (state_q == IDLE) begin
                  err_d = 1'b1;
               end
            end
            CTRL_TAIL: begin
               if (state_q == COLLECT) begin
                  if (idx_q == IDX_FULL) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     store   = 1'b1;
                     words_d = 3'(idx_q) + 3'd1;
                     state_d = HOLD;
                  end
               end else begin
                  if (state_q == IDLE) begin
                     err_d = 1'b1;
                  end
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end

      for (int i = 0; i < MAX_WORDS; i++) begin
         if (store && (idx_q == IDX_W'(i))) begin
            data_d[16*i +: 16] = payload;
         end
      end

      if (err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         data_q    <= '0;
         idx_q     <= '0;
         src_q     <= '0;
         words_q   <= '0;
         err_q     <= 1'b0;
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         src_q     <= src_d;
         words_q   <= words_d;
         err_q     <= err_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.RD_EN     = rd_en;
   assign bus.MSG_VALID = (state_q == HOLD);
   assign bus.MSG_DATA  = data_q;
   assign bus.MSG_WORDS = words_q;
   assign bus.MSG_SRC   = src_q;
   assign bus.ERR       = err_q;
   assign bus.PKT_CNT   = pkt_cnt_q;
   assign bus.ERR_CNT   = err_cnt_q;
endmodule

// File: tb/tb_flit_depacketizer.sv
// Bench for flit_depacketizer: a table of packet vectors plus backpressure, reset and
// counter-boundary sequences; expected messages are queued as flits are pushed.
module tb_flit_depacketizer;
   localparam int         MAX_WORDS = 4;
   localparam logic [3:0] NODE      = 4'd3;

   typedef struct packed {
      logic [63:0] data;
      logic [2:0]  words;
      logic [3:0]  src;
   } msg_t;

   typedef struct {
      int   n;
      bit   has_msg;
      msg_t msg;
      int   errs;
   } vec_t;

   logic CLK = 1'b0;
   logic RST;

   flit_depacketizer_if #(.MAX_WORDS(MAX_WORDS)) bus ();

   flit_depacketizer #(.NODE_ID(NODE), .MAX_WORDS(MAX_WORDS)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   logic [18:0] fifo[$];
   msg_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          err_seen = 0;
   int          drain_cycles = 0;
   int          exp_pkt = 0;
   int          exp_err = 0;
   logic        last_pop = 1'b0;
   logic        last_hs = 1'b0;

   function automatic logic [18:0] head(input logic here, input logic [3:0] dest, input logic [3:0] src);
      return {here, 2'b01, dest, src, 8'h5A};
   endfunction
   function automatic logic [18:0] body(input logic [15:0] p);
      return {1'b0, 2'b10, p};
   endfunction
   function automatic logic [18:0] tail(input logic [15:0] p);
      return {1'b0, 2'b11, p};
   endfunction
   function automatic logic [18:0] idle_flit(input logic [15:0] p);
      return {1'b0, 2'b00, p};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic present();
      bus.FIFO_EMPTY = (fifo.size() == 0);
      bus.RD_DATA    = (fifo.size() != 0) ? fifo[0] : 19'h0;
   endtask

   task automatic check_msg();
      msg_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_msg actual=data %h words %0d src %0d required=no message",
                  bus.MSG_DATA, bus.MSG_WORDS, bus.MSG_SRC);
      end else begin
         e = exp_q.pop_front();
         chk("msg_data", bus.MSG_DATA, e.data);
         chk("msg_words", 64'(bus.MSG_WORDS), 64'(e.words));
         chk("msg_src", 64'(bus.MSG_SRC), 64'(e.src));
         $display("msg data=%h words=%0d src=%0d", bus.MSG_DATA, bus.MSG_WORDS, bus.MSG_SRC);
      end
   endtask

   // One clock: sample pop/handshake/ERR at the falling edge, update the buffer after the rising edge.
   task automatic tick();
      @(negedge CLK);
      last_pop = bus.RD_EN;
      last_hs  = bus.MSG_VALID && bus.MSG_READY;
      if (bus.ERR) err_seen++;
      if (last_hs) check_msg();
      if (last_pop && fifo.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL pop_empty actual=RD_EN 1 required=RD_EN 0 with empty buffer");
      end
      @(posedge CLK);
      #1;
      if (last_pop && fifo.size() != 0) void'(fifo.pop_front());
      present();
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (n < max && (fifo.size() != 0 || exp_q.size() != 0)) begin
         tick();
         n++;
      end
      drain_cycles = n;
      checks++;
      if (fifo.size() != 0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout actual=flits %0d msgs %0d required=0 0", fifo.size(), exp_q.size());
      end
      repeat (2) tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[11];
      logic [18:0] vf[11][8];
      int          n;

      vf[0][0] = head(1'b1, 4'd3, 4'd5); vf[0][1] = body(16'hAAAA); vf[0][2] = tail(16'hBBBB);
      vecs[0] = '{n: 3, has_msg: 1'b1, msg: '{64'h0000_0000_BBBB_AAAA, 3'd2, 4'd5}, errs: 0};
      vf[1][0] = body(16'h1234);
      vecs[1] = '{n: 1, has_msg: 1'b0, msg: '0, errs: 1};
      vf[2][0] = head(1'b1, 4'd2, 4'd1); vf[2][1] = body(16'h0101); vf[2][2] = tail(16'h0202);
      vecs[2] = '{n: 3, has_msg: 1'b0, msg: '0, errs: 1};
      vf[3][0] = head(1'b1, 4'd3, 4'd6);
      for (int k = 1; k <= 5; k++) vf[3][k] = body(16'(k));
      vf[3][6] = tail(16'h0006);
      vecs[3] = '{n: 7, has_msg: 1'b0, msg: '0, errs: 1};
      vf[4][0] = head(1'b1, 4'd3, 4'd7); vf[4][1] = tail(16'h0042);
      vecs[4] = '{n: 2, has_msg: 1'b1, msg: '{64'h42, 3'd1, 4'd7}, errs: 0};
      vf[5][0] = head(1'b1, 4'd3, 4'd1); vf[5][1] = body(16'h0011); vf[5][2] = head(1'b1, 4'd3, 4'd9);
      vf[5][3] = body(16'h00C0); vf[5][4] = tail(16'h00D0);
      vecs[5] = '{n: 5, has_msg: 1'b1, msg: '{64'h0000_0000_00D0_00C0, 3'd2, 4'd9}, errs: 1};
      vf[6][0] = head(1'b0, 4'd3, 4'd2); vf[6][1] = tail(16'h0303);
      vecs[6] = '{n: 2, has_msg: 1'b0, msg: '0, errs: 1};
      vf[7][0] = head(1'b1, 4'd3, 4'd10); vf[7][1] = body(16'h1111); vf[7][2] = body(16'h2222);
      vf[7][3] = body(16'h3333); vf[7][4] = tail(16'h4444);
      vecs[7] = '{n: 5, has_msg: 1'b1, msg: '{64'h4444_3333_2222_1111, 3'd4, 4'd10}, errs: 0};
      vf[8][0] = idle_flit(16'h0F0F); vf[8][1] = head(1'b1, 4'd3, 4'd2); vf[8][2] = idle_flit(16'h0E0E);
      vf[8][3] = tail(16'h5555);
      vecs[8] = '{n: 4, has_msg: 1'b1, msg: '{64'h5555, 3'd1, 4'd2}, errs: 0};
      vf[9][0] = head(1'b1, 4'd3, 4'd11);
      for (int k = 1; k <= 4; k++) vf[9][k] = body(16'(k));
      vf[9][5] = tail(16'h0005);
      vecs[9] = '{n: 6, has_msg: 1'b0, msg: '0, errs: 1};
      vf[10][0] = tail(16'h0707);
      vecs[10] = '{n: 1, has_msg: 1'b0, msg: '0, errs: 1};

      RST = 1'b1;
      bus.MSG_READY = 1'b0;
      fifo.push_back(head(1'b1, 4'd3, 4'd1));
      present();
      repeat (2) tick();
      chk("rst_rd_en", 64'(bus.RD_EN), 64'd0);
      chk("rst_valid", 64'(bus.MSG_VALID), 64'd0);
      chk("rst_data", bus.MSG_DATA, 64'd0);
      chk("rst_words", 64'(bus.MSG_WORDS), 64'd0);
      chk("rst_src", 64'(bus.MSG_SRC), 64'd0);
      chk("rst_err", 64'(bus.ERR), 64'd0);
      chk("rst_pkt_cnt", 64'(bus.PKT_CNT), 64'd0);
      chk("rst_err_cnt", 64'(bus.ERR_CNT), 64'd0);
      fifo.delete();
      present();
      RST = 1'b0;
      bus.MSG_READY = 1'b1;
      tick();

      for (int v = 0; v < 11; v++) begin
         int e0;
         e0 = err_seen;
         for (int k = 0; k < vecs[v].n; k++) fifo.push_back(vf[v][k]);
         if (vecs[v].has_msg) begin
            exp_q.push_back(vecs[v].msg);
            exp_pkt++;
         end
         exp_err += vecs[v].errs;
         present();
         drain(100);
         $display("vec%0d flits=%0d err_pulses=%0d pkt_cnt=%0d err_cnt=%0d",
                  v, vecs[v].n, err_seen - e0, bus.PKT_CNT, bus.ERR_CNT);
         chk($sformatf("vec%0d_err_pulses", v), 64'(err_seen - e0), 64'(vecs[v].errs));
         chk($sformatf("vec%0d_err_cnt", v), 64'(bus.ERR_CNT), 64'(8'(exp_err)));
         chk($sformatf("vec%0d_pkt_cnt", v), 64'(bus.PKT_CNT), 64'(8'(exp_pkt)));
      end

      // Backpressure: complete packet held while three more flits wait in the buffer.
      bus.MSG_READY = 1'b0;
      fifo.push_back(head(1'b1, 4'd3, 4'd4)); fifo.push_back(tail(16'h0077));
      fifo.push_back(head(1'b1, 4'd3, 4'd4)); fifo.push_back(body(16'h0088)); fifo.push_back(tail(16'h0099));
      exp_q.push_back('{64'h77, 3'd1, 4'd4});
      exp_q.push_back('{64'h0000_0000_0099_0088, 3'd2, 4'd4});
      exp_pkt += 2;
      present();
      n = 0;
      while (!bus.MSG_VALID && n < 20) begin tick(); n++; end
      chk("bp_valid", 64'(bus.MSG_VALID), 64'd1);
      chk("bp_flits_left", 64'(fifo.size()), 64'd3);
      repeat (4) begin
         tick();
         chk("bp_rd_en", 64'(last_pop), 64'd0);
         chk("bp_valid_hold", 64'(bus.MSG_VALID), 64'd1);
         chk("bp_data_hold", bus.MSG_DATA, 64'h77);
         chk("bp_words_hold", 64'(bus.MSG_WORDS), 64'd1);
      end
      chk("bp_flits_kept", 64'(fifo.size()), 64'd3);
      bus.MSG_READY = 1'b1;
      tick();
      chk("bp_handshake", 64'(last_hs), 64'd1);
      tick();
      chk("bp_pop_resume", 64'(last_pop), 64'd1);
      drain(50);
      $display("backpressure pkt_cnt=%0d", bus.PKT_CNT);
      chk("bp_pkt_cnt", 64'(bus.PKT_CNT), 64'(8'(exp_pkt)));

      // Reset while a message is held: outputs must clear without waiting for a clock edge.
      bus.MSG_READY = 1'b0;
      fifo.push_back(head(1'b1, 4'd3, 4'd8)); fifo.push_back(body(16'hDEAD)); fifo.push_back(tail(16'hBEEF));
      present();
      n = 0;
      while (!bus.MSG_VALID && n < 20) begin tick(); n++; end
      chk("r1_valid_before", 64'(bus.MSG_VALID), 64'd1);
      fifo.push_back(head(1'b1, 4'd3, 4'd1));
      present();
      #1 RST = 1'b1;
      #1;
      $display("reset_in_hold valid=%0d data=%h pkt_cnt=%0d", bus.MSG_VALID, bus.MSG_DATA, bus.PKT_CNT);
      chk("r1_valid", 64'(bus.MSG_VALID), 64'd0);
      chk("r1_data", bus.MSG_DATA, 64'd0);
      chk("r1_words", 64'(bus.MSG_WORDS), 64'd0);
      chk("r1_src", 64'(bus.MSG_SRC), 64'd0);
      chk("r1_pkt_cnt", 64'(bus.PKT_CNT), 64'd0);
      chk("r1_err_cnt", 64'(bus.ERR_CNT), 64'd0);
      chk("r1_rd_en", 64'(bus.RD_EN), 64'd0);
      tick();
      RST = 1'b0;
      fifo.delete();
      present();
      exp_pkt = 0;
      exp_err = 0;

      // Reset in the middle of collecting a packet.
      bus.MSG_READY = 1'b1;
      fifo.push_back(head(1'b1, 4'd3, 4'd8)); fifo.push_back(body(16'hDEAD)); fifo.push_back(body(16'hBEEF));
      present();
      n = 0;
      while (fifo.size() != 0 && n < 20) begin tick(); n++; end
      tick();
      #1 RST = 1'b1;
      #1;
      chk("r2_valid", 64'(bus.MSG_VALID), 64'd0);
      chk("r2_data", bus.MSG_DATA, 64'd0);
      tick();
      RST = 1'b0;
      present();

      for (int i = 0; i < 256; i++) begin
         fifo.push_back(head(1'b1, 4'd3, 4'(i)));
         fifo.push_back(tail(16'(i + 1)));
         exp_q.push_back('{64'(i + 1), 3'd1, 4'(i)});
      end
      present();
      drain(2000);
      $display("b2b packets=256 cycles=%0d pkt_cnt=%0d err_cnt=%0d", drain_cycles, bus.PKT_CNT, bus.ERR_CNT);
      chk("b2b_cycles", 64'(drain_cycles), 64'd768);
      chk("b2b_pkt_wrap", 64'(bus.PKT_CNT), 64'd0);
      chk("b2b_err_cnt", 64'(bus.ERR_CNT), 64'd0);

      begin
         int e0;
         e0 = err_seen;
         for (int i = 0; i < 260; i++) fifo.push_back(tail(16'hE000));
         present();
         drain(400);
         $display("err_saturation pulses=%0d err_cnt=%0d", err_seen - e0, bus.ERR_CNT);
         chk("sat_err_pulses", 64'(err_seen - e0), 64'd260);
         chk("sat_err_cnt", 64'(bus.ERR_CNT), 64'd255);
         chk("sat_pkt_cnt", 64'(bus.PKT_CNT), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
